piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 118 +++++++++++
 tb/tb_piso_serializer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in / serial-out shifter with a valid/ready load handshake.
// A word is accepted in IDLE, then presented one bit per enabled clock edge in
// SHIFT. After the last bit is consumed the block returns to IDLE and pulses
// done for one cycle. Only one word is ever in flight.
//
// Parameters
//   WIDTH      parallel word width (2..32)
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous reset, active low
//   en          in   shift enable; one bit consumed per edge with en=1 in SHIFT
//   din         in   parallel word, sampled only when a load is accepted
//   load_valid  in   din holds a word to send
//   load_ready  out  block accepts a word this cycle (state decode only)
//   sout        out  serial bit currently presented (register bit, no logic)
//   sout_valid  out  sout carries a payload bit
//   done        out  one-cycle pulse after the last bit of a word is consumed
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CW-1:0]    r_cnt,   w_cnt_nxt;
  logic             r_done,  w_done_nxt;
  logic [WIDTH-1:0] w_shifted;

  // Move one position toward the output end and back-fill with zero. Because
  // every word is fully shifted out (or cleared by reset) before IDLE, the
  // register is all zeros in IDLE, which is what keeps sout at 0 there.
  assign w_shifted = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                               : {1'b0, r_shift[WIDTH-1:1]};

  // NOTE: every always_comb target gets a default first, so no path through
  // the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        // en is deliberately ignored here; only a load changes state.
        if (load_valid) begin
          w_shift_nxt = din;
          w_cnt_nxt   = '0;
          w_state_nxt = SHIFT;
        end
      end

      SHIFT: begin
        // load_valid/din are ignored, so a word in flight is never replaced.
        if (en) begin
          w_shift_nxt = w_shifted;
          if (r_cnt == LAST) begin
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign load_ready = (r_state == IDLE);
  assign sout_valid = (r_state == SHIFT);
  assign sout       = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
  assign done       = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//
// Two instances (MSB-first and LSB-first) share one stimulus stream. When a
// load is going to be accepted, the expected bit order for each instance is
// pushed to its queue; each enabled cycle in SHIFT pops one bit. Every cycle
// the outputs of both instances are compared against the queue heads and the
// expected busy/done status, plus directed checks at the interesting points.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] din;
  logic         load_valid;

  logic ready_m, sout_m, sv_m, done_m;
  logic ready_l, sout_l, sv_l, done_l;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard / expected status
  bit q_m[$];
  bit q_l[$];
  bit busy     = 1'b0;
  bit exp_done = 1'b0;
  int n_done_m = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (ready_m),
    .sout       (sout_m),
    .sout_valid (sv_m),
    .done       (done_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (ready_l),
    .sout       (sout_l),
    .sout_valid (sv_l),
    .done       (done_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare at the falling edge, advance the expected
  // model using the inputs that the next rising edge will see, then return
  // 1 time unit after that rising edge so the caller can drive new inputs.
  task automatic step();
    @(negedge clk);
    check("ready_m", ready_m, !busy);
    check("ready_l", ready_l, !busy);
    check("valid_m", sv_m, busy);
    check("valid_l", sv_l, busy);
    check("sout_m", sout_m, busy ? q_m[0] : 1'b0);
    check("sout_l", sout_l, busy ? q_l[0] : 1'b0);
    check("done_m", done_m, exp_done);
    check("done_l", done_l, exp_done);
    if (done_m === 1'b1) n_done_m++;

    exp_done = 1'b0;
    if (busy) begin
      if (en) begin
        void'(q_m.pop_front());
        void'(q_l.pop_front());
        if (q_m.size() == 0) begin
          busy     = 1'b0;
          exp_done = 1'b1;
        end
      end
    end else if (load_valid) begin
      for (int i = 0; i < W; i++) begin
        q_m.push_back(din[W-1-i]);
        q_l.push_back(din[i]);
      end
      busy = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst        = 1'b0;
    en         = 1'b0;
    din        = '0;
    load_valid = 1'b0;

    // Reset state, checked before any clock edge.
    #3;
    check("rst_ready", ready_m, 1'b1);
    check("rst_valid", sv_m, 1'b0);
    check("rst_sout", sout_m, 1'b0);
    check("rst_done", done_m, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // A5, en held high; idle cycles with en=1 and no load do nothing.
    en = 1'b1;
    steps(2);
    load_valid = 1'b1;
    din        = 8'hA5;
    step();
    load_valid = 1'b0;
    din        = 8'h00;
    n_done_m   = 0;
    steps(8);
    check("a5_done_c9", done_m, 1'b1);
    check("a5_ready_c9", ready_m, 1'b1);
    steps(3);
    check("a5_done_cnt", n_done_m, 1);

    // F0 with en toggling, then a long stall mid-word.
    load_valid = 1'b1;
    din        = 8'hF0;
    step();
    load_valid = 1'b0;
    n_done_m   = 0;
    for (int i = 0; i < 10; i++) begin
      en = (i % 2 == 0);
      step();
    end
    en = 1'b0;
    steps(7);
    check("f0_stall_valid", sv_m, 1'b1);
    for (int i = 0; i < 6; i++) begin
      en = (i % 2 == 0);
      step();
    end
    en = 1'b1;
    steps(3);
    check("f0_done_cnt", n_done_m, 1);

    // 3C with load_valid held and din=FF during SHIFT; FF enters after done.
    load_valid = 1'b1;
    din        = 8'h3C;
    step();
    din = 8'hFF;
    steps(8);
    check("3c_ready_idle", ready_m, 1'b1);
    check("3c_done_idle", done_m, 1'b1);
    step();
    load_valid = 1'b0;
    din        = 8'h00;
    steps(10);

    // Back-to-back 81 then 7E with load_valid held.
    load_valid = 1'b1;
    din        = 8'h81;
    n_done_m   = 0;
    step();
    din = 8'h7E;
    steps(8);
    check("b2b_gap_ready", ready_m, 1'b1);
    step();
    check("b2b_second_busy", sv_m, 1'b1);
    load_valid = 1'b0;
    steps(10);
    check("b2b_done_cnt", n_done_m, 2);

    // FF, asynchronous reset after 3 enabled bits.
    load_valid = 1'b1;
    din        = 8'hFF;
    step();
    load_valid = 1'b0;
    steps(3);
    #2;
    rst = 1'b0;
    #1;
    check("arst_sout", sout_m, 1'b0);
    check("arst_valid", sv_m, 1'b0);
    check("arst_done", done_m, 1'b0);
    check("arst_ready", ready_m, 1'b1);
    check("arst_sout_l", sout_l, 1'b0);
    q_m.delete();
    q_l.delete();
    busy     = 1'b0;
    exp_done = 1'b0;
    @(posedge clk);
    #1;
    check("arst_hold_ready", ready_m, 1'b1);
    check("arst_hold_done", done_m, 1'b0);

    // First edge after reset release accepts a load.
    rst        = 1'b1;
    load_valid = 1'b1;
    din        = 8'h5A;
    n_done_m   = 0;
    step();
    check("post_rst_loaded", sv_m, 1'b1);
    load_valid = 1'b0;
    steps(10);
    check("post_rst_done_cnt", n_done_m, 1);
    check("queue_empty", q_m.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
